// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL bit layout and tap-select encodings for multi_timer.
// Also provides the helper that turns (base, channel, offset) into a bus address.
package multi_timer_pkg;

    localparam logic [15:0] OFS_DIV    = 16'd0;
    localparam logic [15:0] OFS_COUNT  = 16'd1;
    localparam logic [15:0] OFS_RELOAD = 16'd2;
    localparam logic [15:0] OFS_CTRL   = 16'd3;
    localparam logic [15:0] CH_STRIDE  = 16'd3;

    localparam int CTRL_W       = 3;
    localparam int CTRL_EN      = 2;
    localparam int CTRL_SEL_MSB = 1;
    localparam int CTRL_SEL_LSB = 0;

    typedef enum logic [1:0] {
        SEL_TAP0 = 2'd0,
        SEL_TAP1 = 2'd1,
        SEL_TAP2 = 2'd2,
        SEL_TAP3 = 2'd3
    } tap_sel_e;

    function automatic logic [15:0] reg_addr(input logic [15:0] base, input int ch,
                                             input logic [15:0] ofs);
        return base + ofs + CH_STRIDE * 16'(ch);
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One reloadable counter: COUNT/RELOAD/CTRL, falling-edge tick on the selected tap, 1-cycle IRQ pulse.
// Build option TIMER_GLITCH_EMU_EN moves edge detection after the enable/select mux (DMG quirk).
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifndef TIMER_GLITCH_EMU_EN
    input  logic              div_wr,
`endif
    input  logic [3:0]        taps,
    input  logic              wr_count,
    input  logic              wr_reload,
    input  logic              wr_ctrl,
    input  logic [7:0]        wdata,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  reload,
    output logic [CTRL_W-1:0] ctrl,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic     en;
    tap_sel_e sel;
    logic     tick;

    assign en  = ctrl[CTRL_EN];
    assign sel = tap_sel_e'(ctrl[CTRL_SEL_MSB:CTRL_SEL_LSB]);

`ifdef TIMER_GLITCH_EMU_EN
    logic mux_cur;
    logic mux_prev;

    // Any 1->0 of the muxed signal ticks, including ones caused by CTRL or DIV writes.
    assign mux_cur = en & taps[sel];
    assign tick    = mux_prev & ~mux_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mux_prev <= 1'b0;
        else        mux_prev <= mux_cur;
    end
`else
    logic [3:0] taps_prev;

    assign tick = en & taps_prev[sel] & ~taps[sel];

    // Forgetting history on a DIV clear stops the forced 1->0 from looking like a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      taps_prev <= '0;
        else if (div_wr) taps_prev <= '0;
        else             taps_prev <= taps;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            reload <= '0;
            ctrl   <= '0;
            irq    <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (wr_reload) reload <= wdata[CNT_W-1:0];
            if (wr_ctrl)   ctrl   <= wdata[CTRL_W-1:0];
            if (wr_count) begin
                count <= wdata[CNT_W-1:0];
            end else if (tick) begin
                if (count == CNT_MAX) begin
                    // A reload value written on this same edge is used immediately.
                    count <= wr_reload ? wdata[CNT_W-1:0] : reload;
                    irq   <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Shared prescaler/DIV plus NUM_CH reloadable counters on an 8-bit bus; IRQ 1 cycle after overflow edge.
// Build option TIMER_GLITCH_EMU_EN selects DMG-accurate spurious ticks in every channel.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          NUM_CH    = 2,
    parameter int          CNT_W     = 8,
    parameter int          PRESC_W   = 17,
    parameter int          TAP0      = 10,
    parameter int          TAP1      = 4,
    parameter int          TAP2      = 6,
    parameter int          TAP3      = 8
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET_L,
    input  logic [15:0]         I_ADDR,
    inout  wire  [7:0]          IO_DATA,
    input  logic                I_RE_L,
    input  logic                I_WE_L,
    output logic [NUM_CH-1:0]   O_IRQ,
    output logic [7:0]          O_DIV_DATA,
    output logic [8*NUM_CH-1:0] O_COUNT_DATA
);

    logic [PRESC_W-1:0] presc;
    logic [3:0]         taps;
    logic               wr;
    logic               div_wr;
    logic [7:0]         wdata;
    logic               rd_hit;
    logic [7:0]         rd_dat;

    logic [CNT_W-1:0]   ch_count  [NUM_CH];
    logic [CNT_W-1:0]   ch_reload [NUM_CH];
    logic [CTRL_W-1:0]  ch_ctrl   [NUM_CH];

    assign wr     = ~I_WE_L;
    assign wdata  = IO_DATA;
    assign div_wr = wr && (I_ADDR == BASE_ADDR + OFS_DIV);

    always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
        if (!I_RESET_L)  presc <= '0;
        else if (div_wr) presc <= '0;
        else             presc <= presc + PRESC_W'(1);
    end

    assign taps       = {presc[TAP3], presc[TAP2], presc[TAP1], presc[TAP0]};
    assign O_DIV_DATA = presc[PRESC_W-1 -: 8];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [15:0] A_COUNT  = reg_addr(BASE_ADDR, g, OFS_COUNT);
        localparam logic [15:0] A_RELOAD = reg_addr(BASE_ADDR, g, OFS_RELOAD);
        localparam logic [15:0] A_CTRL   = reg_addr(BASE_ADDR, g, OFS_CTRL);

        multi_timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (I_CLOCK),
            .rst_n     (I_RESET_L),
`ifndef TIMER_GLITCH_EMU_EN
            .div_wr    (div_wr),
`endif
            .taps      (taps),
            .wr_count  (wr && (I_ADDR == A_COUNT)),
            .wr_reload (wr && (I_ADDR == A_RELOAD)),
            .wr_ctrl   (wr && (I_ADDR == A_CTRL)),
            .wdata     (wdata),
            .count     (ch_count[g]),
            .reload    (ch_reload[g]),
            .ctrl      (ch_ctrl[g]),
            .irq       (O_IRQ[g])
        );

        assign O_COUNT_DATA[8*g +: 8] = 8'(ch_count[g]);
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_dat = '0;
        if (I_ADDR == BASE_ADDR + OFS_DIV) begin
            rd_hit = 1'b1;
            rd_dat = O_DIV_DATA;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (I_ADDR == reg_addr(BASE_ADDR, i, OFS_COUNT)) begin
                rd_hit = 1'b1;
                rd_dat = 8'(ch_count[i]);
            end
            if (I_ADDR == reg_addr(BASE_ADDR, i, OFS_RELOAD)) begin
                rd_hit = 1'b1;
                rd_dat = 8'(ch_reload[i]);
            end
            if (I_ADDR == reg_addr(BASE_ADDR, i, OFS_CTRL)) begin
                rd_hit = 1'b1;
                rd_dat = 8'(ch_ctrl[i]);
            end
        end
    end

    assign IO_DATA = (rd_hit && !I_RE_L) ? rd_dat : 8'hzz;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (NUM_CH=2, default taps); bus is pulled up so an undriven read shows 0xFF.
module tb_multi_timer;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_CNT0 = 16'hFF05;
    localparam logic [15:0] A_RLD0 = 16'hFF06;
    localparam logic [15:0] A_CTL0 = 16'hFF07;
    localparam logic [15:0] A_CNT1 = 16'hFF08;
    localparam logic [15:0] A_RLD1 = 16'hFF09;
    localparam logic [15:0] A_CTL1 = 16'hFF0A;

`ifdef TIMER_GLITCH_EMU_EN
    localparam logic [7:0] GLITCH = 8'd1;
`else
    localparam logic [7:0] GLITCH = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic        re_l;
    logic        we_l;
    logic        drv;
    logic [7:0]  drv_dat;
    wire  [7:0]  io_data;
    logic [1:0]  irq;
    logic [7:0]  div_dat;
    logic [15:0] count_dat;

    int checks = 0;
    int errors = 0;
    int c      = 0;

    always #5 clk = ~clk;

    assign io_data = drv ? drv_dat : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (io_data[g]);
    end

    multi_timer dut (
        .I_CLOCK      (clk),
        .I_RESET_L    (rst_n),
        .I_ADDR       (addr),
        .IO_DATA      (io_data),
        .I_RE_L       (re_l),
        .I_WE_L       (we_l),
        .O_IRQ        (irq),
        .O_DIV_DATA   (div_dat),
        .O_COUNT_DATA (count_dat)
    );

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; data captured at the next posedge; returns at the following negedge.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        drv_dat = d;
        drv     = 1'b1;
        we_l    = 1'b0;
        @(posedge clk);
        #1;
        we_l = 1'b1;
        drv  = 1'b0;
        @(negedge clk);
        c++;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        re_l = 1'b0;
        #1;
        d    = io_data;
        re_l = 1'b1;
        #1;
    endtask

    task automatic step_to(input int t);
        while (c < t) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic div_anchor();
        bus_write(A_DIV, 8'h00);
        c = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int irq0_n;
        int irq1_n;

        vecs[0]  = '{1'b1, A_RLD0, 8'h5A, 8'h5A};
        vecs[1]  = '{1'b1, A_RLD1, 8'hC3, 8'hC3};
        vecs[2]  = '{1'b1, A_CTL1, 8'hF8, 8'h00};
        vecs[3]  = '{1'b1, A_CNT1, 8'h3C, 8'h3C};
        vecs[4]  = '{1'b1, A_CTL1, 8'hFB, 8'h03};
        vecs[5]  = '{1'b0, 16'hFF0B, 8'h00, 8'hFF};
        vecs[6]  = '{1'b0, 16'hFF03, 8'h00, 8'hFF};
        vecs[7]  = '{1'b1, A_CTL0, 8'hF2, 8'h02};
        vecs[8]  = '{1'b1, A_DIV, 8'hAB, 8'h00};
        vecs[9]  = '{1'b0, A_RLD0, 8'h00, 8'h5A};
        vecs[10] = '{1'b1, A_CNT0, 8'h81, 8'h81};
        vecs[11] = '{1'b0, A_CNT1, 8'h00, 8'h3C};

        rst_n   = 1'b0;
        addr    = 16'h0000;
        re_l    = 1'b1;
        we_l    = 1'b1;
        drv     = 1'b0;
        drv_dat = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_count", {16'h0, count_dat}, 32'h0);
        check("rst_div", {24'h0, div_dat}, 32'h0);
        check("rst_irq", {30'h0, irq}, 32'h0);
        addr = A_CTL0;
        #1;
        check("rst_hiz", {24'h0, io_data}, 32'hFF);
        bus_read(A_DIV, rd);
        check("rst_rd_div", {24'h0, rd}, 32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Register access table, all channels disabled
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
            bus_read(vecs[i].a, rd);
            check($sformatf("vec%0d", i), {24'h0, rd}, {24'h0, vecs[i].exp});
        end

        // Test 1: sel1 (bit 4) ticks once per 32 cycles
        do_reset();
        bus_write(A_CTL0, 8'h05);
        div_anchor();
        bus_write(A_CNT0, 8'h00);
        bus_write(A_RLD0, 8'h00);
        step_to(32); check("t1_c32", {24'h0, count_dat[7:0]}, 32'h00);
        step_to(33); check("t1_c33", {24'h0, count_dat[7:0]}, 32'h01);
        step_to(64); check("t1_c64", {24'h0, count_dat[7:0]}, 32'h01);
        step_to(65); check("t1_c65", {24'h0, count_dat[7:0]}, 32'h02);

        // Test 2: overflow to RELOAD with a single-cycle IRQ
        div_anchor();
        bus_write(A_CNT0, 8'hFE);
        bus_write(A_RLD0, 8'hA0);
        step_to(32); check("t2_pre", {24'h0, count_dat[7:0]}, 32'hFE);
        step_to(33); check("t2_ff", {24'h0, count_dat[7:0]}, 32'hFF);
        step_to(64); check("t2_irq_early", {30'h0, irq}, 32'h0);
        step_to(65);
        check("t2_reload", {24'h0, count_dat[7:0]}, 32'hA0);
        check("t2_irq", {30'h0, irq}, 32'h1);
        step_to(66); check("t2_irq_end", {30'h0, irq}, 32'h0);

        // Test 3: COUNT write on the overflow edge wins, no IRQ
        div_anchor();
        bus_write(A_CNT0, 8'hFF);
        step_to(32);
        bus_write(A_CNT0, 8'h33);
        check("t3_count", {24'h0, count_dat[7:0]}, 32'h33);
        check("t3_no_irq", {30'h0, irq}, 32'h0);

        // Test 4: RELOAD write on the overflow edge loads new data, IRQ fires
        div_anchor();
        bus_write(A_CNT0, 8'hFF);
        step_to(32);
        bus_write(A_RLD0, 8'h77);
        check("t4_count", {24'h0, count_dat[7:0]}, 32'h77);
        check("t4_irq", {30'h0, irq}, 32'h1);
        bus_read(A_RLD0, rd);
        check("t4_rld", {24'h0, rd}, 32'h77);

        // Reset while the IRQ pulse is high
        rst_n = 1'b0;
        #1;
        check("rm_irq", {30'h0, irq}, 32'h0);
        check("rm_count", {16'h0, count_dat}, 32'h0);
        check("rm_div", {24'h0, div_dat}, 32'h0);
        bus_read(A_RLD0, rd);
        check("rm_rld", {24'h0, rd}, 32'h00);
        addr = A_CNT0;
        #1;
        check("rm_hiz", {24'h0, io_data}, 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 6a: disabling while tap is 1
        bus_write(A_CTL0, 8'h05);
        div_anchor();
        bus_write(A_CNT0, 8'h10);
        step_to(20);
        bus_write(A_CTL0, 8'h01);
        step_to(40);
        check("t6_ctrl", {24'h0, count_dat[7:0]}, {24'h0, 8'h10 + GLITCH});
        bus_read(A_CTL0, rd);
        check("t6_ctrl_rd", {24'h0, rd}, 32'h01);

        // Test 6b: DIV clear while tap is 1
        bus_write(A_CTL0, 8'h05);
        div_anchor();
        bus_write(A_CNT0, 8'h20);
        step_to(20);
        div_anchor();
        step_to(10);
        check("t6_div", {24'h0, count_dat[7:0]}, {24'h0, 8'h20 + GLITCH});

        // Test 5: both channels over 8193 cycles from a DIV clear
        do_reset();
        bus_write(A_CTL0, 8'h05);
        bus_write(A_CTL1, 8'h04);
        div_anchor();
        irq0_n = 0;
        irq1_n = 0;
        for (int i = 0; i < 8193; i++) begin
            @(negedge clk);
            if (irq[0]) irq0_n++;
            if (irq[1]) irq1_n++;
        end
        check("t5_cnt0", {24'h0, count_dat[7:0]}, 32'h00);
        check("t5_cnt1", {24'h0, count_dat[15:8]}, 32'h04);
        check("t5_irq0", irq0_n, 1);
        check("t5_irq1", irq1_n, 0);
        check("t5_div", {24'h0, div_dat}, 32'h10);
        bus_read(A_DIV, rd);
        check("t5_div_rd", {24'h0, rd}, 32'h10);
        bus_read(A_CNT1, rd);
        check("t5_cnt1_rd", {24'h0, rd}, 32'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
